plic_lite: RTL and testbench

Memory-mapped platform-level interrupt controller (PLIC) that serves the core's external-interrupt port. It is the responder on the `core_*` register bus and the source of `plic_notif`, which feeds the core's external-pending input. The block latches level-sensitive device interrupts through per-source gateways and arbitrates by priority against a threshold. It implements the claim/complete handshake through a single register.

---
 rtl/plic_pkg.sv | 19 +
 rtl/plic_arbiter.sv | 30 +++
 rtl/plic_lite.sv | 121 ++++++++++++
 tb/tb_plic_lite.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared definitions for the platform-level interrupt controller:
// register offsets, source-ID width and the gateway state encoding.
package plic_pkg;

  localparam int unsigned ID_W = 5;

  localparam logic [23:0] PLIC_PRIO_BASE = 24'h000000;
  localparam logic [23:0] PLIC_PEND      = 24'h001000;
  localparam logic [23:0] PLIC_EN        = 24'h002000;
  localparam logic [23:0] PLIC_THRESH    = 24'h200000;
  localparam logic [23:0] PLIC_CLAIM     = 24'h200004;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PEND,
    GW_INSERV
  } gw_state_e;

endpackage

// File: rtl/plic_arbiter.sv
// Combinational priority arbiter: highest priority above threshold wins,
// ties resolved toward the lowest source ID; 0 means no candidate.
import plic_pkg::*;

module plic_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic [NUM_SRC*PRIO_W-1:0] prio,
  input  logic [NUM_SRC-1:0]        elig,
  input  logic [PRIO_W-1:0]         threshold,
  output logic [ID_W-1:0]           best_id
);

  logic [PRIO_W-1:0] best_prio;

  // Seeding with the threshold makes "strictly greater" both the threshold
  // test and the tie-break (a later equal priority never displaces).
  always_comb begin
    best_id   = '0;
    best_prio = threshold;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/plic_lite.sv
// PLIC top level: per-source gateways, register file, claim/complete
// handling, registered read data and registered external notification.
import plic_pkg::*;

module plic_lite #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] intr_bundle,
  input  logic               core_wen,
  input  logic               core_ren,
  input  logic [23:0]        core_addr,
  input  logic [31:0]        core_wdata,
  output logic [31:0]        core_rdata,
  output logic               plic_notif
);

  localparam logic [21:0] PRIO_WORD   = PLIC_PRIO_BASE[23:2];
  localparam logic [21:0] PEND_WORD   = PLIC_PEND[23:2];
  localparam logic [21:0] EN_WORD     = PLIC_EN[23:2];
  localparam logic [21:0] THRESH_WORD = PLIC_THRESH[23:2];
  localparam logic [21:0] CLAIM_WORD  = PLIC_CLAIM[23:2];

  logic [21:0]               word;
  gw_state_e                 gw      [NUM_SRC];
  gw_state_e                 gw_next [NUM_SRC];
  logic [NUM_SRC*PRIO_W-1:0] prio_q;
  logic [NUM_SRC-1:0]        en_q;
  logic [NUM_SRC-1:0]        pend;
  logic [NUM_SRC-1:0]        elig;
  logic [PRIO_W-1:0]         thresh_q;
  logic [ID_W-1:0]           best_id;
  logic                      claim_fire;
  logic                      complete_fire;
  logic [31:0]               rd_mux;
  logic                      unused_addr_bits;

  assign word             = core_addr[23:2];
  assign unused_addr_bits = ^core_addr[1:0];

  // A simultaneous write wins, so a read of the claim register is dropped.
  assign claim_fire    = core_ren && !core_wen && (word == CLAIM_WORD) && (best_id != '0);
  assign complete_fire = core_wen && (word == CLAIM_WORD);

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pend[i] = (gw[i] == GW_PEND);
    end
  end

  assign elig = pend & en_q;

  plic_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_arbiter (
    .prio      (prio_q),
    .elig      (elig),
    .threshold (thresh_q),
    .best_id   (best_id)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      gw_next[i] = gw[i];
      case (gw[i])
        GW_IDLE:   if (intr_bundle[i]) gw_next[i] = GW_PEND;
        GW_PEND:   if (claim_fire && (best_id == ID_W'(i + 1))) gw_next[i] = GW_INSERV;
        GW_INSERV: if (complete_fire && (core_wdata == 32'(i + 1))) gw_next[i] = GW_IDLE;
        default:   gw_next[i] = GW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (reset) gw[i] <= GW_IDLE;
      else       gw[i] <= gw_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= '0;
      en_q     <= '0;
      thresh_q <= '0;
    end else if (core_wen) begin
      if (word == EN_WORD)     en_q     <= core_wdata[NUM_SRC:1];
      if (word == THRESH_WORD) thresh_q <= core_wdata[PRIO_W-1:0];
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (word == PRIO_WORD + 22'(i + 1)) prio_q[i*PRIO_W +: PRIO_W] <= core_wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (word == PEND_WORD)   rd_mux = 32'({pend, 1'b0});
    if (word == EN_WORD)     rd_mux = 32'({en_q, 1'b0});
    if (word == THRESH_WORD) rd_mux = 32'(thresh_q);
    if (word == CLAIM_WORD)  rd_mux = 32'(best_id);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (word == PRIO_WORD + 22'(i + 1)) rd_mux = 32'(prio_q[i*PRIO_W +: PRIO_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      core_rdata <= '0;
      plic_notif <= 1'b0;
    end else begin
      plic_notif <= (best_id != '0);
      if (core_wen && core_ren) core_rdata <= '0;
      else if (core_ren)        core_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: stimulus pushes expected values into
// queues, a negedge monitor pops and compares them against the DUT.
import plic_pkg::*;

module tb_plic_lite;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  intr;
  logic        core_wen;
  logic        core_ren;
  logic [23:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        plic_notif;

  typedef struct {
    string       name;
    logic [31:0] want;
    bit          sel;
  } chk_t;

  chk_t        rq[$];
  chk_t        cq[$];
  chk_t        mc;
  logic [31:0] act;
  int          total = 0;
  int          bad   = 0;
  bit          rd_pend = 1'b0;
  bit          done = 1'b0;

  always #5 clk = ~clk;

  plic_lite #(
    .NUM_SRC (8),
    .PRIO_W  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .intr_bundle (intr),
    .core_wen    (core_wen),
    .core_ren    (core_ren),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .plic_notif  (plic_notif)
  );

  always @(posedge clk) rd_pend <= core_ren;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h expected no read", core_rdata);
      end else begin
        mc = rq.pop_front();
        total++;
        if (core_rdata !== mc.want) begin
          bad++;
          $display("FAIL %s: got %0h expected %0h", mc.name, core_rdata, mc.want);
        end
      end
    end
    if (cq.size() != 0) begin
      mc  = cq.pop_front();
      act = mc.sel ? core_rdata : {31'b0, plic_notif};
      total++;
      if (act !== mc.want) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h", mc.name, act, mc.want);
      end
    end
    if (done) begin
      if (rq.size() + cq.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending checks expected 0", rq.size() + cq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    core_addr  = a;
    core_wdata = d;
    core_wen   = 1'b1;
    cyc();
    core_wen   = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] e, input string n);
    chk_t c;
    c.name = n;
    c.want = e;
    c.sel  = 1'b0;
    rq.push_back(c);
    core_addr = a;
    core_ren  = 1'b1;
    cyc();
    core_ren  = 1'b0;
  endtask

  task automatic wrrd(input logic [23:0] a, input logic [31:0] d, input string n);
    chk_t c;
    c.name = n;
    c.want = '0;
    c.sel  = 1'b0;
    rq.push_back(c);
    core_addr  = a;
    core_wdata = d;
    core_wen   = 1'b1;
    core_ren   = 1'b1;
    cyc();
    core_wen   = 1'b0;
    core_ren   = 1'b0;
  endtask

  task automatic chk(input logic [31:0] e, input bit sel, input string n);
    chk_t c;
    c.name = n;
    c.want = e;
    c.sel  = sel;
    cq.push_back(c);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; intr = '0; core_wen = 1'b0; core_ren = 1'b0;
    core_addr = '0; core_wdata = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk(32'd0, 1'b0, "rst_notif");
    chk(32'd0, 1'b1, "rst_rdata");
    rd(PLIC_PEND,  32'd0, "rst_pend");
    rd(PLIC_EN,    32'd0, "rst_en");
    rd(PLIC_CLAIM, 32'd0, "rst_claim");

    // single source flow
    wr(24'h00000C, 32'd2);
    wr(PLIC_EN, 32'h8);
    wr(PLIC_THRESH, 32'd0);
    intr = 8'h04;
    cyc();
    chk(32'd0, 1'b0, "notif_lat0");
    cyc();
    chk(32'd1, 1'b0, "notif_rise");
    rd(PLIC_CLAIM, 32'd3, "claim3");
    chk(32'd1, 1'b0, "notif_hold");
    cyc();
    chk(32'd0, 1'b0, "notif_after_claim");
    rd(PLIC_CLAIM, 32'd0, "claim_inserv");
    rd(PLIC_PEND,  32'd0, "pend_inserv");
    wr(PLIC_CLAIM, 32'd3);
    cyc();
    chk(32'd0, 1'b0, "notif_repend0");
    cyc();
    chk(32'd1, 1'b0, "notif_repend");
    rd(PLIC_PEND, 32'h8, "pend_repend");
    intr = 8'h00;
    rd(PLIC_CLAIM, 32'd3, "claim3b");
    wr(PLIC_CLAIM, 32'd3);

    // priority and tie-break
    wr(24'h00000C, 32'd0);
    wr(24'h000008, 32'd5);
    wr(24'h000014, 32'd5);
    wr(24'h000004, 32'd7);
    wr(PLIC_EN, 32'h1FE);
    intr = 8'hFF;
    cyc();
    rd(PLIC_CLAIM, 32'd1, "claim_p7");
    rd(PLIC_CLAIM, 32'd2, "claim_tie_lo");
    rd(PLIC_CLAIM, 32'd5, "claim_tie_hi");
    rd(PLIC_CLAIM, 32'd0, "claim_none");
    rd(PLIC_PEND, 32'h1D8, "pend_mixed");
    wr(PLIC_CLAIM, 32'd1);
    wr(PLIC_CLAIM, 32'd2);
    wr(PLIC_CLAIM, 32'd5);
    cyc();
    intr = 8'h00;

    // threshold and enable
    wr(24'h000010, 32'd3);
    intr = 8'h08;
    wr(PLIC_EN, 32'h10);
    wr(PLIC_THRESH, 32'd3);
    cyc(); cyc();
    chk(32'd0, 1'b0, "notif_thresh_eq");
    wr(PLIC_THRESH, 32'd2);
    chk(32'd0, 1'b0, "notif_thresh_lag");
    cyc();
    chk(32'd1, 1'b0, "notif_thresh_lt");
    wr(PLIC_EN, 32'h0);
    cyc();
    chk(32'd0, 1'b0, "notif_en_clr");
    rd(PLIC_PEND,   32'h1FE, "pend_en_clr");
    rd(PLIC_EN,     32'h0,   "en_clr");
    rd(PLIC_THRESH, 32'd2,   "thresh_rd");
    rd(24'h000010,  32'd3,   "prio4_rd");

    // illegal and simultaneous accesses
    wr(PLIC_EN, 32'h10);
    rd(PLIC_CLAIM, 32'd4, "claim4");
    wr(PLIC_CLAIM, 32'd0);
    wr(PLIC_CLAIM, 32'd9);
    wr(PLIC_CLAIM, 32'd2);
    rd(PLIC_PEND, 32'h1EE, "pend_bad_complete");
    wr(PLIC_PEND, 32'hFF);
    rd(PLIC_PEND, 32'h1EE, "pend_ro");
    wr(24'h000000, 32'd7);
    rd(24'h000000, 32'd0, "unmapped0");
    rd(24'h003000, 32'd0, "unmapped");
    rd(24'h000024, 32'd0, "prio_out_of_range");
    rd(24'h000004, 32'd7, "prio1_kept");
    wrrd(PLIC_THRESH, 32'd5, "wr_rd_same");
    rd(PLIC_THRESH, 32'd5, "thresh_wr_rd");
    wr(PLIC_CLAIM, 32'd4);
    intr = 8'h00;

    // reset mid-service
    wr(24'h00000C, 32'd2);
    wr(PLIC_THRESH, 32'd0);
    wr(PLIC_EN, 32'h8);
    intr = 8'h04;
    rd(PLIC_CLAIM, 32'd3, "claim3_pre_rst");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd(PLIC_PEND,  32'h0, "pend_after_rst");
    rd(PLIC_PEND,  32'h8, "pend_repend_rst");
    chk(32'd0, 1'b0, "notif_rst");
    rd(PLIC_EN,    32'h0, "en_rst");
    rd(PLIC_CLAIM, 32'd0, "claim_rst");
    rd(PLIC_PEND,  32'h8, "pend_after_empty_claim");
    rd(24'h00000C, 32'd0, "prio3_rst");

    cyc(); cyc();
    done = 1'b1;
  end

endmodule
